nids_pkt_scheduler: RTL and testbench
=====================================

# nids_pkt_scheduler

Packet scheduler between feature sources and the NIDS inference pipeline (`top_pipeline`). Two requesters (0 = HPS bridge, 1 = on-chip replay/test source) are arbitrated round-robin. Each granted feature vector is issued as a one-cycle `pkt_valid` pulse. An in-order source tag is tracked per in-flight packet. Results are buffered in a result FIFO so the consumer can apply backpressure without ever dropping a pipeline result.

## Interface
- `N_FEATURES`, 28, feature words per packet
- `DATA_WIDTH`, 32, feature and score width
- `MAX_INFLIGHT`, 8, outstanding-packet limit (power of 2, ≥2)
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  allows new accepts
- `req_valid`  in  2  per-requester packet available
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req0_features`, `req1_features`  in  `N_FEATURES`×`DATA_WIDTH`  requester vectors
- `pkt_features`  out  `N_FEATURES`×`DATA_WIDTH`  to pipeline
- `pkt_valid`  out  1  issue pulse to pipeline
- `valid_out`, `attack_detected`  in  1 each  pipeline result
- `major_score`, `minor_score`  in  `DATA_WIDTH` each  pipeline scores
- `res_valid`  out  1  result FIFO head valid
- `res_ready`  in  1  consumer pop
- `res_src`  out  1  head result's requester ID
- `res_attack`  out  1  head result's attack flag
- `res_major`, `res_minor`  out  `DATA_WIDTH` each  head result's scores
- `busy`  out  1  outstanding ≠ 0
- `inflight_cnt`  out  $clog2(MAX_INFLIGHT)+1  packets issued, result not yet returned
- `attack_cnt0`, `attack_cnt1`  out  16 each  saturating attack counts per source
- `orphan_err`  out  1  sticky flag: result arrived with tag FIFO empty

## Operation
- `outstanding = inflight_cnt + result-FIFO occupancy`.
- `credit = enable && outstanding < MAX_INFLIGHT`.
- Arbitration: register `rr_pri` (reset 0).
  - `req_ready[i] = credit && req_valid[i] && (rr_pri==i || !req_valid[1-i])`.
  - `req_ready` is combinational from `req_valid`.
- Accept (`req_valid[i] && req_ready[i]`) does all of the following:
  - latch `req{i}_features` into `pkt_features`;
  - pulse `pkt_valid` the next cycle;
  - push `i` into the tag FIFO;
  - increment `inflight_cnt`;
  - set `rr_pri <= 1-i`.
- `rr_pri` is unchanged when no accept occurs.
- `pkt_features` holds its last issued value between pulses.
- Result (`valid_out`):
  - pop the tag FIFO;
  - push {tag, attack, major, minor} into the result FIFO;
  - decrement `inflight_cnt`;
  - if attack, increment `attack_cnt[tag]`, saturating at 16'hFFFF.
- Orphan result (`valid_out` with tag FIFO empty):
  - result dropped; no counter change;
  - `orphan_err` set, cleared only by `rst`.
- Pop: `res_valid && res_ready` removes the head. `res_*` always show the head.
- Simultaneous events:
  - Accept and `valid_out` in the same cycle leave `inflight_cnt` unchanged.
  - `valid_out` and pop in the same cycle leave FIFO occupancy unchanged.
  - The credit computation uses the registered counts only; no same-cycle bypass.
- Result-FIFO overflow is impossible by the credit rule. The RTL carries an assertion for it.
- `enable` low blocks accepts only. In-flight results still drain and pop normally.
- `rst` mid-operation clears both FIFOs, all counters, `rr_pri`, `orphan_err`, `pkt_valid`, and `pkt_features` (to 0). The pipeline is reset alongside.

## Timing
- Reset values: all outputs 0, except `req_ready`, which is combinational and 0 while counters are 0 and `req_valid` is 0.
- Accept at cycle N → `pkt_valid` = 1 in cycle N+1 for exactly one cycle.
- `valid_out` at cycle M:
  - `res_valid` = 1 from M+1 when the FIFO was empty;
  - `inflight_cnt` and the attack counters update at M+1.
- Credit freed by a pop at cycle P → a new accept is possible at P+1.
- Throughput: one accept per cycle while credit allows.
- Results are in order; the pipeline is assumed never to reorder.

## Structure
- Package `nids_sched_pkg`:
  - `typedef logic src_id_t`;
  - `typedef struct packed {src_id_t src; logic attack; logic [31:0] major, minor;} nids_result_t`;
  - constant `ATTACK_CNT_MAX = 16'hFFFF`.
- Sub-module `nids_sync_fifo` (parameters WIDTH, DEPTH; synchronous active-high `rst`; push/pop/full/empty/count), instantiated twice:
  - tag FIFO: width 1, depth `MAX_INFLIGHT`;
  - result FIFO: `nids_result_t`, depth `MAX_INFLIGHT`.
- Scheduler top holds the arbiter, credit logic, and counters.

## Test plan
- Both `req_valid` held high, `res_ready`=1, pipeline model latency 5 → grants alternate 0,1,0,1…; `res_src` sequence matches; `inflight_cnt` peaks at 5.
- `res_ready`=0, requester 0 continuously valid → exactly 8 accepts, then `req_ready`=0 and `busy`=1. One pop → exactly one further accept on the next cycle.
- Accept and `valid_out` in the same cycle at `inflight_cnt`=3 → stays 3. `valid_out` with pop at occupancy 2 → stays 2.
- Source 1 sends 70000 attack results → `attack_cnt1` = 16'hFFFF, `attack_cnt0` = 0.
- Inject `valid_out` with nothing issued → `orphan_err`=1 and no `res_valid`. `rst` clears it.
- Assert `rst` with 4 in flight and 2 buffered → next cycle all counters 0, `res_valid`=0, `busy`=0, `pkt_valid`=0.

Source files
------------

// File: rtl/nids_sched_pkg.sv
// ---------------------------------------------------------------------------
// nids_sched_pkg
// Shared types and constants for the NIDS packet scheduler.
//   src_id_t       : requester identifier (0 = HPS bridge, 1 = replay source)
//   nids_result_t  : one buffered pipeline result {src, attack, major, minor}
//   ATTACK_CNT_MAX : saturation value of the per-source attack counters
// ---------------------------------------------------------------------------
package nids_sched_pkg;

    typedef logic src_id_t;

    typedef struct packed {
        src_id_t     src;
        logic        attack;
        logic [31:0] major;
        logic [31:0] minor;
    } nids_result_t;

    localparam logic [15:0] ATTACK_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/nids_sync_fifo.sv
// ---------------------------------------------------------------------------
// nids_sync_fifo
// Single-clock FIFO with occupancy count. Reading is first-word-fall-through:
// o_data always shows the head entry while o_empty is low.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_data  : write strobe and data (ignored when full without pop)
//   i_pop           : remove head (ignored when empty)
//   o_data          : head entry
//   o_full, o_empty : status flags
//   o_count         : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module nids_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle; a pop from an empty FIFO is simply ignored.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    assign o_data  = r_mem[r_rdPtr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the count unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nids_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// nids_pkt_scheduler
// Round-robin packet scheduler in front of the NIDS inference pipeline.
// Two requesters share the pipeline; each accepted feature vector is issued
// as a one-cycle pkt_valid pulse, its source tag is queued in order, and the
// returning results are buffered so the consumer can stall without loss.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   enable                        : permits new accepts
//   req_valid[1:0], req_ready     : per-requester handshake (ready one-hot)
//   req0_features, req1_features  : requester feature vectors
//   pkt_features, pkt_valid       : issue to pipeline
//   valid_out, attack_detected,
//   major_score, minor_score      : pipeline result
//   res_valid, res_ready          : result FIFO head handshake
//   res_src, res_attack,
//   res_major, res_minor          : head result fields
//   busy, inflight_cnt            : outstanding work status
//   attack_cnt0, attack_cnt1      : saturating attack counts per source
//   orphan_err                    : sticky, result seen with no tag queued
// ---------------------------------------------------------------------------
module nids_pkt_scheduler
    import nids_sched_pkg::*;
#(
    parameter int N_FEATURES   = 28,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [1:0]                         req_valid,
    output logic [1:0]                         req_ready,
    input  logic [N_FEATURES*DATA_WIDTH-1:0]   req0_features,
    input  logic [N_FEATURES*DATA_WIDTH-1:0]   req1_features,
    output logic [N_FEATURES*DATA_WIDTH-1:0]   pkt_features,
    output logic                               pkt_valid,
    input  logic                               valid_out,
    input  logic                               attack_detected,
    input  logic [DATA_WIDTH-1:0]              major_score,
    input  logic [DATA_WIDTH-1:0]              minor_score,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic                               res_src,
    output logic                               res_attack,
    output logic [DATA_WIDTH-1:0]              res_major,
    output logic [DATA_WIDTH-1:0]              res_minor,
    output logic                               busy,
    output logic [$clog2(MAX_INFLIGHT):0]      inflight_cnt,
    output logic [15:0]                        attack_cnt0,
    output logic [15:0]                        attack_cnt1,
    output logic                               orphan_err
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int RW = $bits(nids_result_t);
    localparam logic [CW:0] LP_MAX = (CW+1)'(MAX_INFLIGHT);

    logic [CW-1:0]                     r_inflight;
    src_id_t                           r_rrPri;
    logic                              r_pktValid;
    logic [N_FEATURES*DATA_WIDTH-1:0]  r_pktFeatures;
    logic [15:0]                       r_attackCnt0;
    logic [15:0]                       r_attackCnt1;
    logic                              r_orphanErr;

    logic [CW:0]    w_outstanding;
    logic           w_credit;
    logic           w_accept;
    src_id_t        w_accSrc;
    logic           w_resultOk;
    src_id_t        w_tag;
    logic           w_tagFull;
    logic           w_tagEmpty;
    logic [CW-1:0]  w_tagCount;
    nids_result_t   w_resIn;
    nids_result_t   w_resHead;
    logic           w_resFull;
    logic           w_resEmpty;
    logic [CW-1:0]  w_resCount;
    logic           w_resPop;

    // Credit counts everything not yet handed to the consumer: packets inside
    // the pipeline plus results waiting in the buffer. Only registered counts
    // are used, so a pop frees its slot for an accept one cycle later.
    assign w_outstanding = {1'b0, r_inflight} + {1'b0, w_resCount};
    assign w_credit      = enable && (w_outstanding < LP_MAX);

    // Round-robin grant: the priority holder wins a tie, a lone requester
    // always wins. At most one ready bit can be high.
    assign req_ready[0] = w_credit && req_valid[0] && (r_rrPri == 1'b0 || !req_valid[1]);
    assign req_ready[1] = w_credit && req_valid[1] && (r_rrPri == 1'b1 || !req_valid[0]);

    assign w_accept = |(req_valid & req_ready);
    assign w_accSrc = req_ready[1];

    // A result is only accepted when a tag is waiting for it; otherwise it is
    // an orphan and is discarded.
    assign w_resultOk = valid_out && !w_tagEmpty;

    nids_sync_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_INFLIGHT)
    ) u_tagFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_resultOk),
        .i_data  (w_accSrc),
        .o_data  (w_tag),
        .o_full  (w_tagFull),
        .o_empty (w_tagEmpty),
        .o_count (w_tagCount)
    );

    assign w_resIn = '{src:    w_tag,
                       attack: attack_detected,
                       major:  major_score,
                       minor:  minor_score};

    assign w_resPop = !w_resEmpty && res_ready;

    nids_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (MAX_INFLIGHT)
    ) u_resFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_resultOk),
        .i_pop   (w_resPop),
        .i_data  (w_resIn),
        .o_data  (w_resHead),
        .o_full  (w_resFull),
        .o_empty (w_resEmpty),
        .o_count (w_resCount)
    );

    // Issue path and arbitration state: an accept latches the winner's
    // features, pulses pkt_valid for one cycle and hands priority to the
    // other requester. Features hold their last value between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pktValid    <= 1'b0;
            r_pktFeatures <= '0;
            r_rrPri       <= 1'b0;
        end else begin
            r_pktValid <= w_accept;
            if (w_accept) begin
                r_pktFeatures <= w_accSrc ? req1_features : req0_features;
                r_rrPri       <= ~w_accSrc;
            end
        end
    end

    // In-flight counter: an issue and a returning result in the same cycle
    // cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_resultOk})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Per-source attack statistics, attributed through the in-order tag, and
    // the sticky orphan flag which only reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_attackCnt0 <= '0;
            r_attackCnt1 <= '0;
            r_orphanErr  <= 1'b0;
        end else begin
            if (w_resultOk && attack_detected) begin
                if (w_tag == 1'b0) begin
                    if (r_attackCnt0 != ATTACK_CNT_MAX) begin
                        r_attackCnt0 <= r_attackCnt0 + 16'd1;
                    end
                end else begin
                    if (r_attackCnt1 != ATTACK_CNT_MAX) begin
                        r_attackCnt1 <= r_attackCnt1 + 16'd1;
                    end
                end
            end
            if (valid_out && w_tagEmpty) begin
                r_orphanErr <= 1'b1;
            end
        end
    end

    // Structural invariants: the credit rule keeps both FIFOs from ever
    // overflowing, and every in-flight packet owns exactly one queued tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_resultOk && w_resFull && !w_resPop));
            assert (!(w_accept && w_tagFull && !w_resultOk));
            assert (w_tagCount == r_inflight);
        end
    end

    assign pkt_valid    = r_pktValid;
    assign pkt_features = r_pktFeatures;
    assign res_valid    = !w_resEmpty;
    assign res_src      = w_resHead.src;
    assign res_attack   = w_resHead.attack;
    assign res_major    = w_resHead.major;
    assign res_minor    = w_resHead.minor;
    assign busy         = (w_outstanding != '0);
    assign inflight_cnt = r_inflight;
    assign attack_cnt0  = r_attackCnt0;
    assign attack_cnt1  = r_attackCnt1;
    assign orphan_err   = r_orphanErr;

endmodule

// File: tb/tb_nids_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nids_pkt_scheduler
// Directed bench for nids_pkt_scheduler. Inputs are driven and outputs
// sampled 2 time units after the rising edge. A small pipeline model returns
// a result 5 cycles after the accept cycle (4 cycles after pkt_valid), with
// major = result index, minor = index ^ 32'h5A5A0000, attack = index%3==0
// unless forced high.
// ---------------------------------------------------------------------------
module tb_nids_pkt_scheduler;

    localparam int FW = 28 * 32;
    localparam logic [FW-1:0] FEAT_A = {28{32'hA0A0_0001}};
    localparam logic [FW-1:0] FEAT_B = {28{32'h0B0B_0002}};

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [FW-1:0] req0_features;
    logic [FW-1:0] req1_features;
    logic [FW-1:0] pkt_features;
    logic          pkt_valid;
    logic          valid_out;
    logic          attack_detected;
    logic [31:0]   major_score;
    logic [31:0]   minor_score;
    logic          res_valid;
    logic          res_ready;
    logic          res_src;
    logic          res_attack;
    logic [31:0]   res_major;
    logic [31:0]   res_minor;
    logic          busy;
    logic [3:0]    inflight_cnt;
    logic [15:0]   attack_cnt0;
    logic [15:0]   attack_cnt1;
    logic          orphan_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] pipe;
    int          out_idx;
    bit          force_attack;

    nids_pkt_scheduler #(
        .N_FEATURES   (28),
        .DATA_WIDTH   (32),
        .MAX_INFLIGHT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req0_features   (req0_features),
        .req1_features   (req1_features),
        .pkt_features    (pkt_features),
        .pkt_valid       (pkt_valid),
        .valid_out       (valid_out),
        .attack_detected (attack_detected),
        .major_score     (major_score),
        .minor_score     (minor_score),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_src         (res_src),
        .res_attack      (res_attack),
        .res_major       (res_major),
        .res_minor       (res_minor),
        .busy            (busy),
        .inflight_cnt    (inflight_cnt),
        .attack_cnt0     (attack_cnt0),
        .attack_cnt1     (attack_cnt1),
        .orphan_err      (orphan_err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pipeline model: drive this cycle's result if one is due.
    task automatic pipe_drive();
        if (pipe[4]) begin
            valid_out       = 1'b1;
            attack_detected = force_attack || (out_idx % 3 == 0);
            major_score     = 32'(out_idx);
            minor_score     = 32'(out_idx) ^ 32'h5A5A_0000;
        end else begin
            valid_out       = 1'b0;
            attack_detected = 1'b0;
            major_score     = '0;
            minor_score     = '0;
        end
    endtask

    // Pipeline model: advance one cycle, recording any issue pulse.
    task automatic pipe_step();
        if (valid_out) out_idx++;
        tick();
        pipe = {pipe[14:0], pkt_valid};
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        enable          = 1'b0;
        req_valid       = 2'b00;
        req0_features   = FEAT_A;
        req1_features   = FEAT_B;
        valid_out       = 1'b0;
        attack_detected = 1'b0;
        major_score     = '0;
        minor_score     = '0;
        res_ready       = 1'b0;
        pipe            = '0;
        out_idx         = 0;
        force_attack    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({req_ready, pkt_valid, res_valid, busy, orphan_err} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {req_ready, pkt_valid, res_valid, busy, orphan_err});
        end
        checks++;
        if ({inflight_cnt, attack_cnt0, attack_cnt1} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got %h expected 0",
                     {inflight_cnt, attack_cnt0, attack_cnt1});
        end
        checks++;
        if (pkt_features !== '0) begin
            errors++;
            $display("[TB] FAIL reset_features: got nonzero expected 0");
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        bit         grant;
        bit         issue_src;
        int         res_k;
        int         peak;
        int         e0;
        int         e1;
        grant     = 1'b0;
        issue_src = 1'b0;
        res_k     = 0;
        peak      = 0;
        do_reset();
        enable    = 1'b1;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            req_valid = (cyc < 40) ? 2'b11 : 2'b00;
            pipe_drive();
            #1;
            exp_rdy = (cyc < 40) ? (grant ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL rr_grant cyc %0d: got %b expected %b", cyc, req_ready, exp_rdy);
            end
            if (cyc < 40) grant = ~grant;
            pipe_step();
            if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
            if (pkt_valid) begin
                checks++;
                if (pkt_features !== (issue_src ? FEAT_B : FEAT_A)) begin
                    errors++;
                    $display("[TB] FAIL rr_features: got %h expected %h",
                             pkt_features[31:0], issue_src ? FEAT_B[31:0] : FEAT_A[31:0]);
                end
                issue_src = ~issue_src;
            end
            if (res_valid) begin
                checks++;
                if ({res_src, res_attack, res_major, res_minor} !==
                    {res_k[0], (res_k % 3 == 0), 32'(res_k), 32'(res_k) ^ 32'h5A5A_0000}) begin
                    errors++;
                    $display("[TB] FAIL rr_result %0d: got src %b atk %b major %0d minor %h expected src %b major %0d",
                             res_k, res_src, res_attack, res_major, res_minor, res_k[0], res_k);
                end
                res_k++;
            end
        end
        checks++;
        if (peak != 5) begin
            errors++;
            $display("[TB] FAIL rr_peak_inflight: got %0d expected 5", peak);
        end
        checks++;
        if (res_k != 40) begin
            errors++;
            $display("[TB] FAIL rr_result_count: got %0d expected 40", res_k);
        end
        checks++;
        if ({busy, res_valid, inflight_cnt} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL rr_drained: got busy %b res_valid %b inflight %0d expected 0 0 0",
                     busy, res_valid, inflight_cnt);
        end
        e0 = 0;
        e1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) begin
                if (k % 2 == 0) e0++;
                else            e1++;
            end
        end
        checks++;
        if (attack_cnt0 !== 16'(e0) || attack_cnt1 !== 16'(e1)) begin
            errors++;
            $display("[TB] FAIL rr_attack_counts: got %0d/%0d expected %0d/%0d",
                     attack_cnt0, attack_cnt1, e0, e1);
        end
    endtask

    task automatic test_credit_limit();
        int accepts;
        accepts = 0;
        do_reset();
        enable    = 1'b1;
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int cyc = 0; cyc < 30; cyc++) begin
            pipe_drive();
            #1;
            if (req_ready[0]) accepts++;
            pipe_step();
        end
        checks++;
        if (accepts != 8) begin
            errors++;
            $display("[TB] FAIL credit_accepts: got %0d expected 8", accepts);
        end
        pipe_drive();
        #1;
        checks++;
        if ({req_ready, busy, res_valid, inflight_cnt} !== 8'b0011_0000) begin
            errors++;
            $display("[TB] FAIL credit_full: got ready %b busy %b res_valid %b inflight %0d expected 00 1 1 0",
                     req_ready, busy, res_valid, inflight_cnt);
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL credit_no_bypass: got %b expected 00", req_ready);
        end
        pipe_step();
        res_ready = 1'b0;
        pipe_drive();
        #1;
        checks++;
        if (req_ready !== 2'b01 || res_major !== 32'd1) begin
            errors++;
            $display("[TB] FAIL credit_after_pop: got ready %b head %0d expected 01 1", req_ready, res_major);
        end
        pipe_step();
        pipe_drive();
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL credit_one_more: got %b expected 00", req_ready);
        end
        pipe_step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        enable    = 1'b1;
        res_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        checks++;
        if (pkt_valid !== 1'b1 || pkt_features !== FEAT_A) begin
            errors++;
            $display("[TB] FAIL issue_pulse: got valid %b feat %h expected 1 %h",
                     pkt_valid, pkt_features[31:0], FEAT_A[31:0]);
        end
        tick();
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (pkt_valid !== 1'b0 || pkt_features !== FEAT_A || inflight_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL issue_hold: got valid %b inflight %0d expected 0 3", pkt_valid, inflight_cnt);
        end
        req_valid   = 2'b01;
        valid_out   = 1'b1;
        major_score = 32'd10;
        tick();
        req_valid = 2'b00;
        checks++;
        if (inflight_cnt !== 4'd3 || res_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_and_result: got inflight %0d res_valid %b expected 3 1",
                     inflight_cnt, res_valid);
        end
        major_score = 32'd11;
        tick();
        major_score = 32'd12;
        res_ready   = 1'b1;
        tick();
        valid_out = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_major !== 32'd11 || inflight_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL push_and_pop: got res_valid %b head %0d inflight %0d expected 1 11 1",
                     res_valid, res_major, inflight_cnt);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_major !== 32'd12) begin
            errors++;
            $display("[TB] FAIL occupancy_two: got res_valid %b head %0d expected 1 12", res_valid, res_major);
        end
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL occupancy_empty: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_saturation();
        int accepts;
        int cyc;
        accepts = 0;
        cyc     = 0;
        do_reset();
        enable       = 1'b1;
        res_ready    = 1'b1;
        force_attack = 1'b1;
        while ((accepts < 70000 || busy) && cyc < 75000) begin
            pipe_drive();
            req_valid = (accepts < 70000) ? 2'b10 : 2'b00;
            #1;
            if (req_ready[1]) accepts++;
            pipe_step();
            cyc++;
        end
        req_valid = 2'b00;
        checks++;
        if (cyc >= 75000) begin
            errors++;
            $display("[TB] FAIL sat_timeout: got %0d accepts expected 70000 drained", accepts);
        end
        checks++;
        if (attack_cnt1 !== 16'hFFFF || attack_cnt0 !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL sat_counts: got %h/%h expected 0000/ffff", attack_cnt0, attack_cnt1);
        end
        checks++;
        if (out_idx != 70000) begin
            errors++;
            $display("[TB] FAIL sat_results: got %0d expected 70000", out_idx);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        enable          = 1'b1;
        valid_out       = 1'b1;
        attack_detected = 1'b1;
        major_score     = 32'd7;
        tick();
        valid_out       = 1'b0;
        attack_detected = 1'b0;
        checks++;
        if ({orphan_err, res_valid, busy, inflight_cnt, attack_cnt0, attack_cnt1} !== {1'b1, 38'b0}) begin
            errors++;
            $display("[TB] FAIL orphan_flag: got err %b res_valid %b busy %b inflight %0d cnt %0d/%0d expected 1 0 0 0 0/0",
                     orphan_err, res_valid, busy, inflight_cnt, attack_cnt0, attack_cnt1);
        end
        tick();
        tick();
        tick();
        checks++;
        if (orphan_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL orphan_sticky: got %b expected 1", orphan_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (orphan_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL orphan_reset: got %b expected 0", orphan_err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        enable    = 1'b1;
        res_ready = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        req_valid = 2'b00;
        valid_out = 1'b1;
        tick();
        tick();
        valid_out = 1'b0;
        checks++;
        if (inflight_cnt !== 4'd4 || res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_setup: got inflight %0d res_valid %b busy %b expected 4 1 1",
                     inflight_cnt, res_valid, busy);
        end
        rst       = 1'b1;
        req_valid = 2'b01;
        tick();
        rst       = 1'b0;
        req_valid = 2'b00;
        #1;
        checks++;
        if ({inflight_cnt, res_valid, busy, pkt_valid, orphan_err, req_ready} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got inflight %0d res_valid %b busy %b pkt_valid %b ready %b expected all 0",
                     inflight_cnt, res_valid, busy, pkt_valid, req_ready);
        end
        checks++;
        if (pkt_features !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_features: got %h expected 0", pkt_features[31:0]);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_simultaneous();
        test_orphan();
        test_mid_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
